// File: rtl/pam4_ber_checker.sv
// PAM4 demapper with a self-synchronising PRBS7 (x^7+x^6+1) bit-error-rate checker.
// Define PAM4_BER_GRAY_MAP_EN to select Gray level-to-bits mapping instead of binary.
module pam4_ber_checker #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int LOCK_SYMBOLS      = 16,
    parameter int LOL_WINDOW        = 64,
    parameter int LOL_THRESHOLD     = 8,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] symbol_in,
    input  logic                                symbol_in_valid,
    input  logic                                clear_stats,
    output logic [1:0]                          data_out,
    output logic                                data_out_valid,
    output logic                                locked,
    output logic [COUNT_WIDTH-1:0]              bit_count,
    output logic [COUNT_WIDTH-1:0]              err_count,
    output logic [COUNT_WIDTH-1:0]              illegal_count
);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int HALF_LVL = SYMBOL_SEPERATION / 2;
    localparam int FULL_LVL = (3 * SYMBOL_SEPERATION) / 2;
    localparam int LOCK_W   = (LOCK_SYMBOLS > 1) ? $clog2(LOCK_SYMBOLS) : 1;
    localparam int WIN_W    = (LOL_WINDOW > 1) ? $clog2(LOL_WINDOW) : 1;
    localparam int WERR_W   = $clog2(LOL_THRESHOLD + 3);

`ifdef PAM4_BER_GRAY_MAP_EN
    localparam logic [1:0] MAP_POS_LO = 2'b11;
    localparam logic [1:0] MAP_POS_HI = 2'b10;
`else
    localparam logic [1:0] MAP_POS_LO = 2'b10;
    localparam logic [1:0] MAP_POS_HI = 2'b11;
`endif

    logic [1:0]        state_reg, state_next;
    logic [6:0]        lfsr_reg, lfsr_next;
    logic [1:0]        seed_cnt_reg, seed_cnt_next;
    logic [LOCK_W-1:0] clean_cnt_reg, clean_cnt_next;
    logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0] win_err_reg, win_err_next;
    logic              locked_reg, locked_next;
    logic [1:0]        data_out_reg;
    logic              data_valid_reg;

    logic              legal;
    logic [1:0]        rx_bits;
    logic [1:0]        exp_bits;
    logic [1:0]        mismatch;
    logic [1:0]        nerr;
    logic [6:0]        lfsr_gen;
    logic [WERR_W-1:0] win_err_sum;
    logic [5:0]        cnt_inc;
    logic [3*COUNT_WIDTH-1:0] cnt_flat;

    always_comb begin
        legal   = 1'b1;
        rx_bits = 2'b00;
        if (int'(symbol_in) == -FULL_LVL)
            rx_bits = 2'b00;
        else if (int'(symbol_in) == -HALF_LVL)
            rx_bits = 2'b01;
        else if (int'(symbol_in) == HALF_LVL)
            rx_bits = MAP_POS_LO;
        else if (int'(symbol_in) == FULL_LVL)
            rx_bits = MAP_POS_HI;
        else
            legal = 1'b0;
    end

    // Two generator steps folded into one cycle: MSB expectation first, then LSB.
    assign exp_bits    = {lfsr_reg[6] ^ lfsr_reg[5], lfsr_reg[5] ^ lfsr_reg[4]};
    assign lfsr_gen    = {lfsr_reg[4:0], exp_bits};
    assign mismatch    = rx_bits ^ exp_bits;
    assign nerr        = legal ? ({1'b0, mismatch[1]} + {1'b0, mismatch[0]}) : 2'd2;
    assign win_err_sum = win_err_reg + WERR_W'(nerr);

    always_comb begin
        state_next     = state_reg;
        lfsr_next      = lfsr_reg;
        seed_cnt_next  = seed_cnt_reg;
        clean_cnt_next = clean_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        locked_next    = locked_reg;
        cnt_inc        = 6'd0;
        if (symbol_in_valid) begin
            cnt_inc[5:4] = {1'b0, ~legal};
            case (state_reg)
                ST_SEED: begin
                    if (!legal) begin
                        seed_cnt_next = 2'd0;
                    end else begin
                        lfsr_next = {lfsr_reg[4:0], rx_bits};
                        if (seed_cnt_reg == 2'd3) begin
                            seed_cnt_next  = 2'd0;
                            clean_cnt_next = '0;
                            state_next     = ST_VERIFY;
                        end else begin
                            seed_cnt_next = seed_cnt_reg + 2'd1;
                        end
                    end
                end
                ST_VERIFY: begin
                    lfsr_next = lfsr_gen;
                    if (nerr != 2'd0) begin
                        state_next    = ST_SEED;
                        seed_cnt_next = 2'd0;
                    end else if (clean_cnt_reg == LOCK_W'(LOCK_SYMBOLS - 1)) begin
                        state_next   = ST_LOCKED;
                        locked_next  = 1'b1;
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        clean_cnt_next = clean_cnt_reg + LOCK_W'(1);
                    end
                end
                ST_LOCKED: begin
                    lfsr_next    = lfsr_gen;
                    cnt_inc[1:0] = 2'd2;
                    cnt_inc[3:2] = nerr;
                    if (win_err_sum > WERR_W'(LOL_THRESHOLD)) begin
                        state_next    = ST_SEED;
                        locked_next   = 1'b0;
                        seed_cnt_next = 2'd0;
                        win_cnt_next  = '0;
                        win_err_next  = '0;
                    end else if (win_cnt_reg == WIN_W'(LOL_WINDOW - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        win_err_next = win_err_sum;
                    end
                end
                default: begin
                    state_next    = ST_SEED;
                    seed_cnt_next = 2'd0;
                    locked_next   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_SEED;
            lfsr_reg       <= 7'h7F;
            seed_cnt_reg   <= 2'd0;
            clean_cnt_reg  <= '0;
            win_cnt_reg    <= '0;
            win_err_reg    <= '0;
            locked_reg     <= 1'b0;
            data_out_reg   <= 2'b00;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            seed_cnt_reg   <= seed_cnt_next;
            clean_cnt_reg  <= clean_cnt_next;
            win_cnt_reg    <= win_cnt_next;
            win_err_reg    <= win_err_next;
            locked_reg     <= locked_next;
            data_out_reg   <= symbol_in_valid ? rx_bits : 2'b00;
            data_valid_reg <= symbol_in_valid;
        end
    end

    // Counter order in cnt_flat/cnt_inc: 0 = bits, 1 = errors, 2 = illegal levels.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [COUNT_WIDTH-1:0] count_reg;
            logic [COUNT_WIDTH:0]   count_sum;

            assign count_sum = {1'b0, count_reg}
                             + {{(COUNT_WIDTH-1){1'b0}}, cnt_inc[gi*2 +: 2]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    count_reg <= '0;
                else if (clear_stats)
                    count_reg <= '0;
                else if (count_sum[COUNT_WIDTH])
                    count_reg <= '1;
                else
                    count_reg <= count_sum[COUNT_WIDTH-1:0];
            end

            assign cnt_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = count_reg;
        end
    endgenerate

    assign data_out       = data_out_reg;
    assign data_out_valid = data_valid_reg;
    assign locked         = locked_reg;
    assign bit_count      = cnt_flat[0 +: COUNT_WIDTH];
    assign err_count      = cnt_flat[COUNT_WIDTH +: COUNT_WIDTH];
    assign illegal_count  = cnt_flat[2*COUNT_WIDTH +: COUNT_WIDTH];

endmodule

// File: tb/tb_pam4_ber_checker.sv
// Scoreboard bench for pam4_ber_checker: PRBS7 source, behavioural checker model, directed lock/error cases.
// Honours PAM4_BER_GRAY_MAP_EN for the transmit mapping so the same sequence runs in either build.
module tb_pam4_ber_checker;

    localparam int SR            = 8;
    localparam int S             = 56;
    localparam int CW            = 32;
    localparam int LOCK_SYMBOLS  = 16;
    localparam int LOL_WINDOW    = 64;
    localparam int LOL_THRESHOLD = 8;
    localparam int L1            = S / 2;
    localparam int L3            = (3 * S) / 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [SR-1:0] symbol_in = '0;
    logic                 symbol_in_valid = 1'b0;
    logic                 clear_stats = 1'b0;
    logic [1:0]           data_out;
    logic                 data_out_valid;
    logic                 locked;
    logic [CW-1:0]        bit_count;
    logic [CW-1:0]        err_count;
    logic [CW-1:0]        illegal_count;

    pam4_ber_checker #(
        .SIGNAL_RESOLUTION(SR),
        .SYMBOL_SEPERATION(S),
        .LOCK_SYMBOLS(LOCK_SYMBOLS),
        .LOL_WINDOW(LOL_WINDOW),
        .LOL_THRESHOLD(LOL_THRESHOLD),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .symbol_in(symbol_in),
        .symbol_in_valid(symbol_in_valid),
        .clear_stats(clear_stats),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .locked(locked),
        .bit_count(bit_count),
        .err_count(err_count),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] data;
        logic       lock;
        longint     bits;
        longint     errs;
        longint     ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int         m_state;
    logic [6:0] m_lfsr;
    int         m_seed, m_clean, m_wcnt, m_werr;
    logic       m_locked;
    longint     m_bits, m_errs, m_ill;

    logic [6:0] tx_lfsr = 7'h35;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic demap(input int lvl, output logic [1:0] b);
        b = 2'b00;
        if (lvl == -L3) begin
            b = 2'b00;
            return 1'b1;
        end
        if (lvl == -L1) begin
            b = 2'b01;
            return 1'b1;
        end
`ifdef PAM4_BER_GRAY_MAP_EN
        if (lvl == L1)  begin b = 2'b11; return 1'b1; end
        if (lvl == L3)  begin b = 2'b10; return 1'b1; end
`else
        if (lvl == L1)  begin b = 2'b10; return 1'b1; end
        if (lvl == L3)  begin b = 2'b11; return 1'b1; end
`endif
        return 1'b0;
    endfunction

    function automatic int lvl_of(input logic [1:0] b);
        case (b)
            2'b00:   return -L3;
            2'b01:   return -L1;
`ifdef PAM4_BER_GRAY_MAP_EN
            2'b11:   return L1;
            default: return L3;
`else
            2'b10:   return L1;
            default: return L3;
`endif
        endcase
    endfunction

    task automatic tx_next(output logic [1:0] b);
        logic nb;
        for (int k = 1; k >= 0; k--) begin
            nb      = tx_lfsr[6] ^ tx_lfsr[5];
            tx_lfsr = {tx_lfsr[5:0], nb};
            b[k]    = nb;
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_lfsr   = 7'h7F;
        m_seed   = 0;
        m_clean  = 0;
        m_wcnt   = 0;
        m_werr   = 0;
        m_locked = 1'b0;
        m_bits   = 0;
        m_errs   = 0;
        m_ill    = 0;
    endtask

    task automatic model_step(input int lvl, input logic clr, output exp_t e);
        logic [1:0] b;
        logic       ok;
        logic       nb;
        int         errs;
        ok   = demap(lvl, b);
        errs = 0;
        if (!ok) m_ill++;
        if (m_state == 0) begin
            if (!ok) begin
                m_seed = 0;
            end else begin
                for (int k = 1; k >= 0; k--) m_lfsr = {m_lfsr[5:0], b[k]};
                m_seed++;
                if (m_seed == 4) begin
                    m_state = 1;
                    m_seed  = 0;
                    m_clean = 0;
                end
            end
        end else begin
            for (int k = 1; k >= 0; k--) begin
                nb     = m_lfsr[6] ^ m_lfsr[5];
                m_lfsr = {m_lfsr[5:0], nb};
                if (ok && nb != b[k]) errs++;
            end
            if (!ok) errs = 2;
            if (m_state == 1) begin
                if (errs != 0) begin
                    m_state = 0;
                    m_seed  = 0;
                end else begin
                    m_clean++;
                    if (m_clean == LOCK_SYMBOLS) begin
                        m_state  = 2;
                        m_locked = 1'b1;
                        m_wcnt   = 0;
                        m_werr   = 0;
                    end
                end
            end else begin
                m_bits += 2;
                m_errs += errs;
                m_werr += errs;
                m_wcnt++;
                if (m_werr > LOL_THRESHOLD) begin
                    m_state  = 0;
                    m_locked = 1'b0;
                    m_seed   = 0;
                    m_wcnt   = 0;
                    m_werr   = 0;
                end else if (m_wcnt == LOL_WINDOW) begin
                    m_wcnt = 0;
                    m_werr = 0;
                end
            end
        end
        if (clr) begin
            m_bits = 0;
            m_errs = 0;
            m_ill  = 0;
        end
        e.data = ok ? b : 2'b00;
        e.lock = m_locked;
        e.bits = m_bits;
        e.errs = m_errs;
        e.ill  = m_ill;
    endtask

    task automatic send_sym(input int lvl, input logic clr);
        exp_t e;
        @(posedge clk); #1;
        check_val("idle_valid", 64'(data_out_valid), 64'(0));
        symbol_in       = SR'(lvl);
        symbol_in_valid = 1'b1;
        clear_stats     = clr;
        model_step(lvl, clr, e);
        sb.push_back(e);
        @(posedge clk); #1;
        symbol_in_valid = 1'b0;
        clear_stats     = 1'b0;
        symbol_in       = '0;
        @(negedge clk);
        e = sb.pop_front();
        check_val("out_valid", 64'(data_out_valid), 64'(1));
        check_val("data_out", 64'(data_out), 64'(e.data));
        check_val("locked", 64'(locked), 64'(e.lock));
        check_val("bit_count", 64'(bit_count), 64'(e.bits));
        check_val("err_count", 64'(err_count), 64'(e.errs));
        check_val("illegal_count", 64'(illegal_count), 64'(e.ill));
    endtask

    task automatic send_clean();
        logic [1:0] b;
        tx_next(b);
        send_sym(lvl_of(b), 1'b0);
    endtask

    task automatic lock_run(output int n);
        n = 0;
        do begin
            send_clean();
            n++;
        end while (!locked && n < 60);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, 64'(data_out_valid), 64'(0));
        check_val({tag, "_data"}, 64'(data_out), 64'(0));
        check_val({tag, "_locked"}, 64'(locked), 64'(0));
        check_val({tag, "_bits"}, 64'(bit_count), 64'(0));
        check_val({tag, "_errs"}, 64'(err_count), 64'(0));
        check_val({tag, "_ill"}, 64'(illegal_count), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_zero_outputs("rst_async");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    initial begin
        int         n;
        logic [1:0] b;
        logic       done;

        model_reset();
        #3;
        check_zero_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_val("idle_locked", 64'(locked), 64'(0));
        end

        // Clean stream: 4 seed + 16 verify symbols
        lock_run(n);
        check_val("first_lock_syms", 64'(n), 64'(20));
        repeat (100) send_clean();
        check_val("bits_after_100", 64'(bit_count), 64'(200));
        check_val("errs_after_100", 64'(err_count), 64'(0));

        // Invert both bits of the next +S/2 symbol
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tx_next(b);
            if (lvl_of(b) == L1) begin
                send_sym(lvl_of(~b), 1'b0);
                done = 1'b1;
            end else begin
                send_sym(lvl_of(b), 1'b0);
            end
        end
        check_val("found_plus_half", 64'(done), 64'(1));
        check_val("single_err_errs", 64'(err_count), 64'(2));
        check_val("single_err_locked", 64'(locked), 64'(1));

        // Roll the window, then five failed decisions inside one window
        repeat (LOL_WINDOW) send_clean();
        for (int i = 0; i < 5; i++) begin
            tx_next(b);
            send_sym(0, 1'b0);
            if (i == 3) check_val("lol_after4_locked", 64'(locked), 64'(1));
        end
        check_val("lol_locked", 64'(locked), 64'(0));
        check_val("lol_illegal", 64'(illegal_count), 64'(5));
        check_val("lol_errs", 64'(err_count), 64'(12));
        lock_run(n);
        check_val("relock_syms", 64'(n), 64'(20));

        // clear_stats together with an errored symbol
        tx_next(b);
        send_sym(lvl_of(~b), 1'b1);
        check_val("clr_bits", 64'(bit_count), 64'(0));
        check_val("clr_errs", 64'(err_count), 64'(0));
        check_val("clr_ill", 64'(illegal_count), 64'(0));
        check_val("clr_locked", 64'(locked), 64'(1));

        // Reset while in VERIFY
        do_reset();
        repeat (6) send_clean();
        check_val("verify_locked", 64'(locked), 64'(0));
        do_reset();
        lock_run(n);
        check_val("post_rst_lock_syms", 64'(n), 64'(20));
        repeat (10) send_clean();
        check_val("post_rst_bits", 64'(bit_count), 64'(20));
        check_val("post_rst_errs", 64'(err_count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
